// File: rtl/cpu_multi_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester IDs
// and the default access timeout.
package cpu_multi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request always wins, and on a tie the
// requester that was not served last wins.
module rr_pick2
  import cpu_multi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_CPU;
    unique case (req)
      2'b01:   gnt_id = REQ_CPU;
      2'b10:   gnt_id = REQ_LDR;
      2'b11:   gnt_id = ~last;
      default: gnt_id = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU and a loader onto one data-memory port (IDLE/ACCESS/RESP).
// Define DMEM_ARB_TIMEOUT_EN to bound ACCESS at TIMEOUT cycles and flag err.
module dmem_arbiter
  import cpu_multi_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          c_req,
  input  logic          l_req,
  input  logic          c_we,
  input  logic          l_we,
  input  logic [AW-1:0] c_addr,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [DW-1:0] l_wdata,
  output logic          c_done,
  output logic          l_done,
  output logic [DW-1:0] c_rdata,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy,
  output logic          owner,
  output logic          err
);

  arb_state_t state;
  logic       rr_last;
  logic       gnt_valid;
  logic       gnt_id;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  logic [CW-1:0] cnt;
  logic          timed_out;
`else
  assign err = 1'b0;
`endif

  rr_pick2 u_pick (
    .req       ({l_req, c_req}),
    .last      (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Memory-side fields are registered on grant so they stay stable for the
  // whole ACCESS phase even if the requester changes its inputs. The done
  // pulse is emitted on the RESP->IDLE edge, so it lands in the first IDLE cycle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
      owner     <= REQ_CPU;
      rr_last   <= REQ_LDR;
      c_done    <= 1'b0;
      l_done    <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
      cnt       <= '0;
      timed_out <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      c_done <= 1'b0;
      l_done <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      err    <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            state   <= ACCESS;
            owner   <= gnt_id;
            busy    <= 1'b1;
            m_en    <= 1'b1;
            m_we    <= (gnt_id == REQ_LDR) ? l_we    : c_we;
            m_addr  <= (gnt_id == REQ_LDR) ? l_addr  : c_addr;
            m_wdata <= (gnt_id == REQ_LDR) ? l_wdata : c_wdata;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt       <= '0;
            timed_out <= 1'b0;
`endif
          end
        end

        ACCESS: begin
          if (m_ack) begin
            state <= RESP;
            m_en  <= 1'b0;
            m_we  <= 1'b0;
            if (!m_we) begin
              if (owner == REQ_LDR) l_rdata <= m_rdata;
              else                  c_rdata <= m_rdata;
            end
          end
`ifdef DMEM_ARB_TIMEOUT_EN
          // A timed-out read returns zero rather than stale data.
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= RESP;
            m_en      <= 1'b0;
            m_we      <= 1'b0;
            timed_out <= 1'b1;
            if (!m_we) begin
              if (owner == REQ_LDR) l_rdata <= '0;
              else                  c_rdata <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          state   <= IDLE;
          busy    <= 1'b0;
          rr_last <= owner;
          c_done  <= (owner == REQ_CPU);
          l_done  <= (owner == REQ_LDR);
`ifdef DMEM_ARB_TIMEOUT_EN
          err     <= timed_out;
`endif
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          m_en  <= 1'b0;
          m_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
